// File: rtl/rf_pkg.sv
// Register-file constants and the writeback queue entry type.
// Latency: n/a. Backpressure: n/a.
package rf_pkg;
    localparam int REG_W     = 16;
    localparam int REG_IDX_W = 4;
    localparam int NUM_REGS  = 1 << REG_IDX_W;
    localparam logic [REG_IDX_W-1:0] ZERO_REG = '0;

    typedef struct packed {
        logic [REG_IDX_W-1:0] dst;
        logic [REG_W-1:0]     data;
    } wb_entry_t;
endpackage

// File: rtl/wb_fifo.sv
// In-order writeback queue: up to two pushes and one pop per cycle, entries exposed by age.
// Latency: a push is visible at the head the cycle after the edge that stores it.
// Backpressure: none; the caller never pushes more than the free slot count.
module wb_fifo
    import rf_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       i_push_cnt,
    input  wb_entry_t        i_push_ent0,
    input  wb_entry_t        i_push_ent1,
    output logic [CNT_W-1:0] o_count,
    output wb_entry_t        o_age_ent [DEPTH],
    output logic [DEPTH-1:0] o_age_vld
);
    wb_entry_t        r_mem [DEPTH];
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_pop;

    function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] p, input int k);
        int s;
        s = int'(p) + k;
        if (s >= DEPTH) s = s - DEPTH;
        return PTR_W'(s);
    endfunction

    // The head is consumed by the RF every cycle it is valid.
    assign w_pop = (r_count != '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else begin
            if (i_push_cnt != 2'd0) r_mem[r_wr_ptr] <= i_push_ent0;
            if (i_push_cnt == 2'd2) r_mem[ptr_add(r_wr_ptr, 1)] <= i_push_ent1;
            r_wr_ptr <= ptr_add(r_wr_ptr, int'(i_push_cnt));
            r_rd_ptr <= ptr_add(r_rd_ptr, w_pop ? 1 : 0);
            r_count  <= r_count + CNT_W'(i_push_cnt) - CNT_W'(w_pop);
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_age
        assign o_age_ent[g] = r_mem[ptr_add(r_rd_ptr, g)];
        assign o_age_vld[g] = (CNT_W'(g) < r_count);
    end

    assign o_count = r_count;
endmodule

// File: rtl/rf_writeback_buffer.sv
// RF write-port master: merges load/ALU results into an in-order queue, supplies read bypass.
// Latency: result accepted at edge N drives the RF write port in cycle N+1.
// Backpressure: mem_ready/alu_ready from free slots; load wins the last slot.
module rf_writeback_buffer
    import rf_pkg::*;
#(
    parameter int DATA_W = REG_W,
    parameter int ADDR_W = REG_IDX_W,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [ADDR_W-1:0] alu_dst,
    input  logic [DATA_W-1:0] alu_data,
    input  logic              mem_valid,
    output logic              mem_ready,
    input  logic [ADDR_W-1:0] mem_dst,
    input  logic [DATA_W-1:0] mem_data,
    output logic              WriteReg,
    output logic [ADDR_W-1:0] DstReg,
    output logic [DATA_W-1:0] DstData,
    input  logic [ADDR_W-1:0] SrcReg1,
    input  logic [DATA_W-1:0] rf_data1,
    output logic [DATA_W-1:0] byp_data1,
    input  logic [ADDR_W-1:0] SrcReg2,
    input  logic [DATA_W-1:0] rf_data2,
    output logic [DATA_W-1:0] byp_data2,
    output logic              empty
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int FW    = CNT_W + 1;

    wb_entry_t        w_mem_ent;
    wb_entry_t        w_alu_ent;
    wb_entry_t        w_push_ent0;
    wb_entry_t        w_age_ent [DEPTH];
    logic [DEPTH-1:0] w_age_vld;
    logic [CNT_W-1:0] w_count;
    logic [FW-1:0]    w_free;
    logic [1:0]       w_push_cnt;
    logic             w_mem_push;
    logic             w_alu_push;

    // The draining head frees its slot at the same edge a new result lands.
    assign w_free = FW'(DEPTH) - {1'b0, w_count} + FW'(w_count != '0);

    assign mem_ready = (w_free >= FW'(1));
    assign alu_ready = (w_free >= FW'(2)) | ((w_free == FW'(1)) & ~mem_valid);

    // R0 results complete the handshake but are dropped here.
    assign w_mem_push = mem_valid & mem_ready & (mem_dst != ZERO_REG);
    assign w_alu_push = alu_valid & alu_ready & (alu_dst != ZERO_REG);

    assign w_mem_ent.dst  = mem_dst;
    assign w_mem_ent.data = mem_data;
    assign w_alu_ent.dst  = alu_dst;
    assign w_alu_ent.data = alu_data;

    assign w_push_cnt  = {1'b0, w_mem_push} + {1'b0, w_alu_push};
    assign w_push_ent0 = w_mem_push ? w_mem_ent : w_alu_ent;

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push_cnt  (w_push_cnt),
        .i_push_ent0 (w_push_ent0),
        .i_push_ent1 (w_alu_ent),
        .o_count     (w_count),
        .o_age_ent   (w_age_ent),
        .o_age_vld   (w_age_vld)
    );

    assign WriteReg = w_age_vld[0];
    assign DstReg   = WriteReg ? w_age_ent[0].dst  : '0;
    assign DstData  = WriteReg ? w_age_ent[0].data : '0;
    assign empty    = (w_count == '0);

    // Walk oldest to youngest so the youngest match is left standing.
    always_comb begin
        byp_data1 = rf_data1;
        byp_data2 = rf_data2;
        for (int k = 0; k < DEPTH; k++) begin
            if (w_age_vld[k] && (w_age_ent[k].dst == SrcReg1)) byp_data1 = w_age_ent[k].data;
            if (w_age_vld[k] && (w_age_ent[k].dst == SrcReg2)) byp_data2 = w_age_ent[k].data;
        end
        if (SrcReg1 == ZERO_REG) byp_data1 = '0;
        if (SrcReg2 == ZERO_REG) byp_data2 = '0;
    end
endmodule

// File: tb/tb_rf_writeback_buffer.sv
// Bench for rf_writeback_buffer: directed vector table, reset corners, randomized model comparison.
module tb_rf_writeback_buffer;
    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        alu_valid = 1'b0, mem_valid = 1'b0;
    logic        alu_ready, mem_ready;
    logic [3:0]  alu_dst = '0, mem_dst = '0;
    logic [15:0] alu_data = '0, mem_data = '0;
    logic        WriteReg, empty;
    logic [3:0]  DstReg;
    logic [15:0] DstData;
    logic [3:0]  SrcReg1 = '0, SrcReg2 = '0;
    logic [15:0] rf_data1 = '0, rf_data2 = '0;
    logic [15:0] byp_data1, byp_data2;

    int n_checks = 0;
    int n_err    = 0;

    typedef struct { logic [3:0] dst; logic [15:0] data; } ent_t;
    ent_t q[$];

    typedef struct {
        logic mv; logic [3:0] md; logic [15:0] mdat;
        logic av; logic [3:0] ad; logic [15:0] adat;
        logic [3:0] s1; logic [15:0] r1; logic [3:0] s2; logic [15:0] r2;
        logic e_wr; logic [3:0] e_dreg; logic [15:0] e_ddat;
        logic e_ar; logic e_mr; logic [15:0] e_b1; logic [15:0] e_b2; logic e_emp;
    } vec_t;
    vec_t vt [11];

    rf_writeback_buffer #(.DATA_W(16), .ADDR_W(4), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_dst(alu_dst), .alu_data(alu_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_dst(mem_dst), .mem_data(mem_data),
        .WriteReg(WriteReg), .DstReg(DstReg), .DstData(DstData),
        .SrcReg1(SrcReg1), .rf_data1(rf_data1), .byp_data1(byp_data1),
        .SrcReg2(SrcReg2), .rf_data2(rf_data2), .byp_data2(byp_data2),
        .empty(empty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic mv, input logic [3:0] md, input logic [15:0] mdat,
                         input logic av, input logic [3:0] ad, input logic [15:0] adat,
                         input logic [3:0] s1, input logic [15:0] r1,
                         input logic [3:0] s2, input logic [15:0] r2);
        mem_valid = mv; mem_dst = md; mem_data = mdat;
        alu_valid = av; alu_dst = ad; alu_data = adat;
        SrcReg1 = s1; rf_data1 = r1; SrcReg2 = s2; rf_data2 = r2;
    endtask

    // Youngest pending write to the register wins; R0 always reads zero.
    function automatic logic [15:0] ref_byp(input logic [3:0] s, input logic [15:0] r);
        logic [15:0] v;
        v = r;
        foreach (q[i]) if (q[i].dst == s) v = q[i].data;
        if (s == 4'd0) v = '0;
        return v;
    endfunction

    task automatic run_cycle(input logic mv, input logic [3:0] md, input logic [15:0] mdat,
                             input logic av, input logic [3:0] ad, input logic [15:0] adat,
                             input logic [3:0] s1, input logic [15:0] r1,
                             input logic [3:0] s2, input logic [15:0] r2);
        int   sz, fr;
        logic e_mr, e_ar;
        @(negedge clk);
        drive(mv, md, mdat, av, ad, adat, s1, r1, s2, r2);
        #1;
        sz   = q.size();
        fr   = DEPTH - sz + ((sz != 0) ? 1 : 0);
        e_mr = (fr >= 1);
        e_ar = (fr >= 2) || ((fr == 1) && !mv);
        chk("m_WriteReg", 16'(WriteReg), 16'(sz != 0));
        chk("m_empty", 16'(empty), 16'(sz == 0));
        chk("m_mem_ready", 16'(mem_ready), 16'(e_mr));
        chk("m_alu_ready", 16'(alu_ready), 16'(e_ar));
        chk("m_byp_data1", byp_data1, ref_byp(s1, r1));
        chk("m_byp_data2", byp_data2, ref_byp(s2, r2));
        if (sz != 0) begin
            chk("m_DstReg", 16'(DstReg), 16'(q[0].dst));
            chk("m_DstData", DstData, q[0].data);
        end
        @(posedge clk);
        if (sz != 0) void'(q.pop_front());
        if (mv && e_mr && md != 4'd0) q.push_back('{md, mdat});
        if (av && e_ar && ad != 4'd0) q.push_back('{ad, adat});
    endtask

    task automatic rand_cycle(input bit both);
        logic       mv, av;
        logic [3:0] md, ad;
        if (both) begin
            mv = 1'b1; av = 1'b1;
            md = 4'($urandom_range(1, 15));
            ad = 4'((int'(md) % 15) + 1);
        end else begin
            mv = ($urandom_range(0, 2) != 0);
            av = ($urandom_range(0, 2) != 0);
            md = 4'($urandom_range(0, 15));
            ad = 4'($urandom_range(0, 15));
        end
        run_cycle(mv, md, 16'($urandom), av, ad, 16'($urandom),
                  4'($urandom_range(0, 15)), 16'($urandom),
                  4'($urandom_range(0, 15)), 16'($urandom));
    endtask

    initial begin
        //        mv md    mdat       av  ad    adat      s1   r1        s2   r2       | wr dreg ddat      ar   mr   b1        b2        emp
        vt[0]  = '{1'b0,4'd0,16'h0000, 1'b1,4'd3,16'h1234, 4'd3,16'h0000, 4'd0,16'h7777, 1'b0,4'd0,16'h0000, 1'b1,1'b1,16'h0000,16'h0000,1'b1};
        vt[1]  = '{1'b0,4'd0,16'h0000, 1'b0,4'd0,16'h0000, 4'd3,16'h0000, 4'd4,16'h0042, 1'b1,4'd3,16'h1234, 1'b1,1'b1,16'h1234,16'h0042,1'b0};
        vt[2]  = '{1'b1,4'd5,16'hAAAA, 1'b1,4'd5,16'h5555, 4'd3,16'h1234, 4'd5,16'h0000, 1'b0,4'd0,16'h0000, 1'b1,1'b1,16'h1234,16'h0000,1'b1};
        vt[3]  = '{1'b0,4'd0,16'h0000, 1'b0,4'd0,16'h0000, 4'd5,16'h0000, 4'd5,16'h0000, 1'b1,4'd5,16'hAAAA, 1'b1,1'b1,16'h5555,16'h5555,1'b0};
        vt[4]  = '{1'b0,4'd0,16'h0000, 1'b0,4'd0,16'h0000, 4'd0,16'hBEEF, 4'd5,16'h0000, 1'b1,4'd5,16'h5555, 1'b1,1'b1,16'h0000,16'h5555,1'b0};
        vt[5]  = '{1'b0,4'd0,16'h0000, 1'b1,4'd0,16'hFFFF, 4'd0,16'hBEEF, 4'd5,16'h5555, 1'b0,4'd0,16'h0000, 1'b1,1'b1,16'h0000,16'h5555,1'b1};
        vt[6]  = '{1'b1,4'd1,16'h0101, 1'b1,4'd2,16'h0202, 4'd0,16'hBEEF, 4'd0,16'h1111, 1'b0,4'd0,16'h0000, 1'b1,1'b1,16'h0000,16'h0000,1'b1};
        vt[7]  = '{1'b1,4'd6,16'h0606, 1'b1,4'd7,16'h0707, 4'd2,16'h0000, 4'd1,16'h0000, 1'b1,4'd1,16'h0101, 1'b0,1'b1,16'h0202,16'h0101,1'b0};
        vt[8]  = '{1'b0,4'd0,16'h0000, 1'b0,4'd0,16'h0000, 4'd6,16'h0000, 4'd7,16'h3333, 1'b1,4'd2,16'h0202, 1'b1,1'b1,16'h0606,16'h3333,1'b0};
        vt[9]  = '{1'b0,4'd0,16'h0000, 1'b0,4'd0,16'h0000, 4'd2,16'h0202, 4'd0,16'h4444, 1'b1,4'd6,16'h0606, 1'b1,1'b1,16'h0202,16'h0000,1'b0};
        vt[10] = '{1'b0,4'd0,16'h0000, 1'b0,4'd0,16'h0000, 4'd1,16'h0101, 4'd6,16'h9999, 1'b0,4'd0,16'h0000, 1'b1,1'b1,16'h0101,16'h9999,1'b1};

        // Power-on reset, checked before the first clock edge.
        #3;
        chk("rst0_WriteReg", 16'(WriteReg), 16'd0);
        chk("rst0_empty", 16'(empty), 16'd1);
        chk("rst0_alu_ready", 16'(alu_ready), 16'd1);
        chk("rst0_mem_ready", 16'(mem_ready), 16'd1);
        chk("rst0_DstReg", 16'(DstReg), 16'd0);
        chk("rst0_DstData", DstData, 16'd0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            drive(vt[i].mv, vt[i].md, vt[i].mdat, vt[i].av, vt[i].ad, vt[i].adat,
                  vt[i].s1, vt[i].r1, vt[i].s2, vt[i].r2);
            #1;
            chk($sformatf("v%0d_WriteReg", i), 16'(WriteReg), 16'(vt[i].e_wr));
            chk($sformatf("v%0d_alu_ready", i), 16'(alu_ready), 16'(vt[i].e_ar));
            chk($sformatf("v%0d_mem_ready", i), 16'(mem_ready), 16'(vt[i].e_mr));
            chk($sformatf("v%0d_byp_data1", i), byp_data1, vt[i].e_b1);
            chk($sformatf("v%0d_byp_data2", i), byp_data2, vt[i].e_b2);
            chk($sformatf("v%0d_empty", i), 16'(empty), 16'(vt[i].e_emp));
            if (vt[i].e_wr) begin
                chk($sformatf("v%0d_DstReg", i), 16'(DstReg), 16'(vt[i].e_dreg));
                chk($sformatf("v%0d_DstData", i), DstData, vt[i].e_ddat);
            end
        end

        // Mixed random traffic, then both producers valid every cycle.
        for (int c = 0; c < 300; c++) rand_cycle(1'b0);
        for (int c = 0; c < 60; c++) rand_cycle(1'b1);

        // Reset pulse with two entries queued: nothing may be written afterwards.
        run_cycle(1'b1, 4'd8, 16'h1111, 1'b1, 4'd9, 16'h2222, 4'd0, 16'h0, 4'd0, 16'h0);
        run_cycle(1'b1, 4'd10, 16'h3333, 1'b1, 4'd11, 16'h4444, 4'd0, 16'h0, 4'd0, 16'h0);
        @(negedge clk);
        drive(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0, 4'd10, 16'h0, 4'd11, 16'h0);
        #2;
        rst = 1'b0;
        #1;
        chk("rst1_WriteReg", 16'(WriteReg), 16'd0);
        chk("rst1_empty", 16'(empty), 16'd1);
        chk("rst1_alu_ready", 16'(alu_ready), 16'd1);
        chk("rst1_mem_ready", 16'(mem_ready), 16'd1);
        chk("rst1_DstReg", 16'(DstReg), 16'd0);
        chk("rst1_byp_data1", byp_data1, 16'd0);
        q.delete();
        @(negedge clk);
        rst = 1'b1;
        run_cycle(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0, 4'd10, 16'h0, 4'd11, 16'h0);
        run_cycle(1'b0, 4'd0, 16'h0, 1'b1, 4'd3, 16'h1234, 4'd3, 16'h0, 4'd0, 16'h0);
        @(negedge clk);
        drive(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0, 4'd3, 16'h0, 4'd0, 16'h0);
        #1;
        chk("post_rst_WriteReg", 16'(WriteReg), 16'd1);
        chk("post_rst_DstReg", 16'(DstReg), 16'd3);
        chk("post_rst_DstData", DstData, 16'h1234);
        chk("post_rst_byp_data1", byp_data1, 16'h1234);
        @(negedge clk);
        #1;
        chk("post_rst_drained", 16'(empty), 16'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
